// File: rtl/prog_loader.sv
// Byte-stream program loader: packs bytes little-endian into 32-bit instructions,
// strobes each into instruction memory, and releases the core once loading finishes.
module prog_loader #(
  parameter int NUM_WORDS      = 256,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             byte_valid,
  input  logic [7:0]                       byte_data,
  output logic                             byte_ready,
  input  logic                             mem_load_done,
  output logic                             load_en,
  output logic [31:0]                      load_inst,
  output logic [$clog2(NUM_WORDS+1)-1:0]   words_loaded,
  output logic                             busy,
  output logic                             done,
  output logic                             err,
  output logic                             core_rst_n
);

  localparam int WL_W = $clog2(NUM_WORDS + 1);
  localparam int TM_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WL_W-1:0] WL_MAX  = WL_W'(NUM_WORDS);
  localparam logic [TM_W-1:0] TM_LIM  = TM_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_RECV, S_WRITE, S_DONE, S_ERR} state_e;

  state_e            state_q, state_d;
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [TM_W-1:0]   timer_q, timer_d;
  logic [23:0]       shift_q, shift_d;
  logic [31:0]       inst_q, inst_d;
  logic [WL_W-1:0]   words_q, words_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      byte_cnt_q <= '0;
      timer_q    <= '0;
      inst_q     <= '0;
      words_q    <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      timer_q    <= timer_d;
      inst_q     <= inst_d;
      words_q    <= words_d;
    end
  end

  // The lower three bytes of a word in progress; always fully overwritten before use.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    timer_d    = timer_q;
    shift_d    = shift_q;
    inst_d     = inst_q;
    words_d    = words_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_RECV;
          byte_cnt_d = '0;
          timer_d    = '0;
        end
      end
      S_RECV: begin
        // Memory-full at a word boundary beats a concurrent byte, which is dropped.
        if (mem_load_done && byte_cnt_q == 2'd0) begin
          state_d = S_DONE;
        end else if (byte_valid) begin
          timer_d    = '0;
          byte_cnt_d = byte_cnt_q + 2'd1;
          case (byte_cnt_q)
            2'd0: shift_d[7:0]   = byte_data;
            2'd1: shift_d[15:8]  = byte_data;
            2'd2: shift_d[23:16] = byte_data;
            default: begin
              inst_d  = {byte_data, shift_q};
              state_d = S_WRITE;
            end
          endcase
        end else if (timer_q >= TM_LIM) begin
          state_d = (byte_cnt_q == 2'd0) ? S_DONE : S_ERR;
        end else if (!(words_q == '0 && byte_cnt_q == 2'd0)) begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WRITE: begin
        if (words_q != WL_MAX) words_d = words_q + 1'b1;
        timer_d = '0;
        state_d = (words_q == WL_MAX - 1'b1) ? S_DONE : S_RECV;
      end
      S_DONE: state_d = S_DONE;
      S_ERR:  state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  assign byte_ready   = (state_q == S_RECV);
  assign load_en      = (state_q == S_WRITE);
  assign load_inst    = inst_q;
  assign words_loaded = words_q;
  assign busy         = (state_q == S_RECV) || (state_q == S_WRITE);
  assign done         = (state_q == S_DONE);
  assign err          = (state_q == S_ERR);
  assign core_rst_n   = (state_q == S_DONE);

endmodule

// File: tb/tb_prog_loader.sv
// Directed-plus-random bench for prog_loader with a byte-list reference model.
module tb_prog_loader;
  localparam int NW = 4;
  localparam int TO = 40;

  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, byte_valid = 1'b0, mem_load_done = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic        byte_ready, load_en, busy, done, err, core_rst_n;
  logic [31:0] load_inst;
  logic [2:0]  words_loaded;

  prog_loader #(.NUM_WORDS(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_load_done(mem_load_done), .load_en(load_en),
    .load_inst(load_inst), .words_loaded(words_loaded), .busy(busy), .done(done),
    .err(err), .core_rst_n(core_rst_n)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] pulses[$];
  logic        prev_en = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (load_en) begin
      pulses.push_back(load_inst);
      chk("ready_low_in_write", {31'd0, byte_ready}, 32'd0);
      chk("no_back_to_back_load_en", {31'd0, prev_en}, 32'd0);
    end
    prev_en = load_en;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; byte_valid = 1'b0; mem_load_done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    pulses.delete();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int g;
    repeat (gap) tick();
    byte_valid = 1'b1;
    byte_data  = b;
    g = 0;
    while (byte_ready !== 1'b1 && g < 100) begin tick(); g++; end
    if (g >= 100) chk("byte_ready_wait", 32'd0, 32'd1);
    tick();
    byte_valid = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_load_en"}, {31'd0, load_en}, 32'd0);
    chk({tag, "_load_inst"}, load_inst, 32'd0);
    chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
    chk({tag, "_words_loaded"}, {29'd0, words_loaded}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_core_rst_n"}, {31'd0, core_rst_n}, 32'd0);
  endtask

  // Reference: word w of a little-endian byte stream.
  function automatic logic [31:0] model_word(input logic [7:0] b[$], input int w);
    return {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
  endfunction

  task automatic chk_words(input string tag, input logic [7:0] b[$], input int nw);
    chk({tag, "_pulse_count"}, pulses.size(), nw);
    for (int i = 0; i < nw && i < pulses.size(); i++)
      chk($sformatf("%s_word%0d", tag, i), pulses[i], model_word(b, i));
  endtask

  task automatic wait_done_or_err(input string tag, input int limit, output int cycles);
    cycles = 0;
    while (!done && !err && cycles < limit) begin tick(); cycles++; end
    if (cycles >= limit) chk({tag, "_end_wait"}, 32'd0, 32'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] bq[$];
    int         c, idx, nwr, rdy_bad;
    logic       r;

    // Reset state
    tick(); tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick();

    // Test 1: two known instructions, with random gaps on the second word
    bq = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'h10, 8'h00};
    pulse_start();
    chk("busy_after_start", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 3; i++) send(bq[i], 0);
    send(bq[3], 0);
    chk("latency_load_en", {31'd0, load_en}, 32'd1);
    chk("latency_load_inst", load_inst, 32'h00A00513);
    for (int i = 4; i < 8; i++) send(bq[i], $urandom_range(0, 5));
    tick(); tick();
    chk_words("t1", bq, 2);
    chk("t1_words_loaded", {29'd0, words_loaded}, 32'd2);
    chk("t1_load_inst_held", load_inst, 32'h00100593);

    // Test 2: end-of-stream timeout -> DONE
    wait_done_or_err("t2", TO + 20, c);
    chk("t2_timeout_window", {31'd0, (c >= TO - 4 && c <= TO + 4)}, 32'd1);
    chk("t2_done", {31'd0, done}, 32'd1);
    chk("t2_core_rst_n", {31'd0, core_rst_n}, 32'd1);
    chk("t2_err", {31'd0, err}, 32'd0);
    chk("t2_busy", {31'd0, busy}, 32'd0);
    byte_valid = 1'b1; byte_data = 8'h55;
    pulse_start();
    repeat (5) tick();
    chk("t2_ready_after_done", {31'd0, byte_ready}, 32'd0);
    chk("t2_still_done", {31'd0, done}, 32'd1);
    chk("t2_no_more_pulses", pulses.size(), 2);
    byte_valid = 1'b0;

    // Test 3: random 6 bytes then idle -> one word, then ERR
    do_reset();
    bq.delete();
    for (int i = 0; i < 6; i++) bq.push_back(8'($urandom));
    pulse_start();
    for (int i = 0; i < 6; i++) send(bq[i], $urandom_range(0, 3));
    wait_done_or_err("t3", TO + 20, c);
    chk_words("t3", bq, 1);
    chk("t3_err", {31'd0, err}, 32'd1);
    chk("t3_done", {31'd0, done}, 32'd0);
    chk("t3_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("t3_words_loaded", {29'd0, words_loaded}, 32'd1);
    pulse_start();
    tick();
    chk("t3_err_sticky", {31'd0, err}, 32'd1);

    // Random program of 1..3 words with random gaps -> clean DONE
    do_reset();
    bq.delete();
    nwr = $urandom_range(1, 3);
    for (int i = 0; i < 4 * nwr; i++) bq.push_back(8'($urandom));
    pulse_start();
    for (int i = 0; i < 4 * nwr; i++) send(bq[i], $urandom_range(0, 6));
    wait_done_or_err("rnd", TO + 20, c);
    chk_words("rnd", bq, nwr);
    chk("rnd_done", {31'd0, done}, 32'd1);
    chk("rnd_words_loaded", {29'd0, words_loaded}, nwr);

    // Test 4: continuous stream of 20 bytes, memory depth 4
    do_reset();
    bq.delete();
    for (int i = 0; i < 20; i++) bq.push_back(8'($urandom));
    pulse_start();
    idx = 0;
    byte_valid = 1'b1;
    for (int cyc = 0; cyc < 80 && idx < 20 && !done; cyc++) begin
      byte_data = bq[idx];
      r = byte_ready;
      tick();
      if (r) idx++;
    end
    repeat (3) tick();
    chk("t4_bytes_accepted", idx, 16);
    chk_words("t4", bq, NW);
    chk("t4_done", {31'd0, done}, 32'd1);
    chk("t4_words_loaded", {29'd0, words_loaded}, NW);
    chk("t4_ready_after_done", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;

    // mem_load_done mid-word is ignored until the word completes
    do_reset();
    bq = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    pulse_start();
    send(bq[0], 0); send(bq[1], 0);
    mem_load_done = 1'b1;
    repeat (3) tick();
    chk("mld_midword_busy", {31'd0, busy}, 32'd1);
    chk("mld_midword_done", {31'd0, done}, 32'd0);
    send(bq[2], 0); send(bq[3], 0);
    wait_done_or_err("mld", 10, c);
    chk_words("mld", bq, 1);
    chk("mld_done", {31'd0, done}, 32'd1);
    chk("mld_words_loaded", {29'd0, words_loaded}, 32'd1);
    mem_load_done = 1'b0;

    // Test 5: bytes ignored before start; no timeout before first byte
    do_reset();
    byte_valid = 1'b1; byte_data = 8'hA5;
    rdy_bad = 0;
    for (int i = 0; i < 50; i++) begin
      if (byte_ready !== 1'b0) rdy_bad++;
      tick();
    end
    byte_valid = 1'b0;
    chk("t5_ready_before_start", rdy_bad, 0);
    chk("t5_no_pulses", pulses.size(), 0);
    pulse_start();
    repeat (3 * TO) tick();
    chk("t5_still_busy", {31'd0, busy}, 32'd1);
    chk("t5_err", {31'd0, err}, 32'd0);
    chk("t5_done", {31'd0, done}, 32'd0);

    // Test 6: async reset mid-word, then restart
    do_reset();
    pulse_start();
    send(8'h11, 0); send(8'h22, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("t6_async");
    tick();
    rst_n = 1'b1;
    tick();
    pulses.delete();
    bq.delete();
    for (int i = 0; i < 4; i++) bq.push_back(8'($urandom));
    pulse_start();
    for (int i = 0; i < 4; i++) send(bq[i], 0);
    tick(); tick();
    chk_words("t6", bq, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
